// File: rtl/sdram_cmd_decoder.sv
// -----------------------------------------------------------------------------
// sdram_cmd_decoder
//
// Pops commands from a command FIFO and, for writes, one word from a
// write-data FIFO, then presents a decoded SDRAM request (row/bank/column,
// byte enables, write data) with a valid/ready handshake.
//
// Both FIFOs have a read latency of one cycle: RDATA is valid in the cycle
// after the REN pulse.
//
// Optional feature (compile-time macro):
//   SDRAM_CMD_ALIGN_CHECK_EN - drop misaligned or oversized commands and pulse
//                              ERR once per dropped command. Write data is
//                              still popped for a dropped write. Without the
//                              macro no command is dropped and ERR stays 0.
//
// Ports:
//   SDRAM_CLK      in   clock, all logic on the rising edge
//   SDRAM_RST      in   asynchronous active-high reset
//   CFIFO_REMPTY   in   command FIFO empty
//   CFIFO_REN      out  command FIFO pop
//   CFIFO_RDATA    in   {write[35], size[34:32], addr[31:0]}
//   WFIFO_REMPTY   in   write-data FIFO empty
//   WFIFO_REN      out  write-data FIFO pop
//   WFIFO_RDATA    in   write data word
//   REQ_VALID      out  request valid (only in OUT)
//   REQ_READY      in   SDRAM core accepts request
//   REQ_WRITE      out  request is a write
//   REQ_ROW/BANK/COL out decoded address
//   REQ_WDATA      out  write data, 0 for reads
//   REQ_BE         out  active-high byte enables
//   ERR            out  one-cycle pulse per dropped command
// -----------------------------------------------------------------------------
module sdram_cmd_decoder #(
    parameter int ROW_BITS = 13,
    parameter int COL_BITS = 10,
    parameter int BA_BITS  = 2
) (
    input  logic                SDRAM_CLK,
    input  logic                SDRAM_RST,
    input  logic                CFIFO_REMPTY,
    output logic                CFIFO_REN,
    input  logic [35:0]         CFIFO_RDATA,
    input  logic                WFIFO_REMPTY,
    output logic                WFIFO_REN,
    input  logic [31:0]         WFIFO_RDATA,
    output logic                REQ_VALID,
    input  logic                REQ_READY,
    output logic                REQ_WRITE,
    output logic [ROW_BITS-1:0] REQ_ROW,
    output logic [BA_BITS-1:0]  REQ_BANK,
    output logic [COL_BITS-1:0] REQ_COL,
    output logic [31:0]         REQ_WDATA,
    output logic [3:0]          REQ_BE,
    output logic                ERR
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLATCH = 3'd1,
        ST_WWAIT  = 3'd2,
        ST_WLATCH = 3'd3,
        ST_OUT    = 3'd4
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    logic                cmd_write_s;
    logic [2:0]          cmd_size_s;
    logic [1:0]          cmd_lsb_s;
    logic                drop_s;
    logic                cfifo_ren_s;
    logic                wfifo_ren_s;
    logic                unused_addr_s;

    logic                valid_r;
    logic                write_r;
    logic [ROW_BITS-1:0] row_r;
    logic [BA_BITS-1:0]  bank_r;
    logic [COL_BITS-1:0] col_r;
    logic [31:0]         wdata_r;
    logic [3:0]          be_r;
    logic                drop_r;
    logic                err_r;

    // Byte enables from transfer size and the two low address bits.
    function automatic logic [3:0] be_calc(input logic [2:0] size, input logic [1:0] lsb);
        case (size)
            3'd0:    be_calc = 4'b0001 << lsb;
            3'd1:    be_calc = lsb[1] ? 4'b1100 : 4'b0011;
            default: be_calc = 4'b1111;
        endcase
    endfunction

    // A command is illegal when it is wider than a word or not naturally aligned.
    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lsb);
        case (size)
            3'd0:    misaligned = 1'b0;
            3'd1:    misaligned = lsb[0];
            3'd2:    misaligned = (lsb != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

    assign cmd_write_s   = CFIFO_RDATA[35];
    assign cmd_size_s    = CFIFO_RDATA[34:32];
    assign cmd_lsb_s     = CFIFO_RDATA[1:0];
    // Upper address bits beyond row/bank/col are intentionally ignored.
    assign unused_addr_s = ^CFIFO_RDATA[31:0];

`ifdef SDRAM_CMD_ALIGN_CHECK_EN
    assign drop_s = misaligned(cmd_size_s, cmd_lsb_s);
`else
    assign drop_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge SDRAM_CLK or posedge SDRAM_RST) begin
        if (SDRAM_RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!CFIFO_REMPTY) state_nxt_s = ST_CLATCH;
                else               state_nxt_s = ST_IDLE;
            end
            ST_CLATCH: begin
                if (!cmd_write_s)       state_nxt_s = drop_s ? ST_IDLE : ST_OUT;
                else if (!WFIFO_REMPTY) state_nxt_s = ST_WLATCH;
                else                    state_nxt_s = ST_WWAIT;
            end
            ST_WWAIT: begin
                if (!WFIFO_REMPTY) state_nxt_s = ST_WLATCH;
                else               state_nxt_s = ST_WWAIT;
            end
            ST_WLATCH: begin
                // A dropped write still consumed its data word; it just never issues.
                if (drop_r) state_nxt_s = ST_IDLE;
                else        state_nxt_s = ST_OUT;
            end
            ST_OUT: begin
                if (REQ_READY) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_OUT;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FIFO pop strobes. These are decoded from the current state and the
    // empty flags (not registered) so a pop lands in the same cycle the FIFO
    // is seen non-empty, which the 2/3-cycle issue latency depends on.
    always_comb begin
        cfifo_ren_s = 1'b0;
        wfifo_ren_s = 1'b0;
        case (state_r)
            ST_IDLE:   cfifo_ren_s = !CFIFO_REMPTY;
            ST_CLATCH: wfifo_ren_s = cmd_write_s && !WFIFO_REMPTY;
            ST_WWAIT:  wfifo_ren_s = !WFIFO_REMPTY;
            default: begin
                cfifo_ren_s = 1'b0;
                wfifo_ren_s = 1'b0;
            end
        endcase
    end

    // Gate with reset so the pops drop to 0 the instant reset asserts.
    assign CFIFO_REN = cfifo_ren_s & ~SDRAM_RST;
    assign WFIFO_REN = wfifo_ren_s & ~SDRAM_RST;

    // Request registers: capture the command in CLATCH, the data word in WLATCH.
    always_ff @(posedge SDRAM_CLK or posedge SDRAM_RST) begin
        if (SDRAM_RST) begin
            valid_r <= 1'b0;
            write_r <= 1'b0;
            row_r   <= '0;
            bank_r  <= '0;
            col_r   <= '0;
            wdata_r <= 32'h0000_0000;
            be_r    <= 4'b0000;
            drop_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            valid_r <= (state_nxt_s == ST_OUT);
            err_r   <= 1'b0;
            if (state_r == ST_CLATCH) begin
                write_r <= cmd_write_s;
                col_r   <= CFIFO_RDATA[2 +: COL_BITS];
                bank_r  <= CFIFO_RDATA[2 + COL_BITS +: BA_BITS];
                row_r   <= CFIFO_RDATA[2 + COL_BITS + BA_BITS +: ROW_BITS];
                be_r    <= be_calc(cmd_size_s, cmd_lsb_s);
                wdata_r <= 32'h0000_0000;
                drop_r  <= drop_s;
                err_r   <= drop_s;
            end else if (state_r == ST_WLATCH) begin
                wdata_r <= WFIFO_RDATA;
            end
        end
    end

    assign REQ_VALID = valid_r;
    assign REQ_WRITE = write_r;
    assign REQ_ROW   = row_r;
    assign REQ_BANK  = bank_r;
    assign REQ_COL   = col_r;
    assign REQ_WDATA = wdata_r;
    assign REQ_BE    = be_r;
    assign ERR       = err_r;

endmodule

// File: tb/tb_sdram_cmd_decoder.sv
module tb_sdram_cmd_decoder;

    localparam int ROW_BITS = 13;
    localparam int COL_BITS = 10;
    localparam int BA_BITS  = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cfifo_rempty, cfifo_ren, wfifo_rempty, wfifo_ren;
    logic [35:0]         cfifo_rdata;
    logic [31:0]         wfifo_rdata;
    logic                req_valid, req_ready, req_write, err;
    logic [ROW_BITS-1:0] req_row;
    logic [BA_BITS-1:0]  req_bank;
    logic [COL_BITS-1:0] req_col;
    logic [31:0]         req_wdata;
    logic [3:0]          req_be;

    sdram_cmd_decoder #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .BA_BITS(BA_BITS)) dut (
        .SDRAM_CLK(clk), .SDRAM_RST(rst),
        .CFIFO_REMPTY(cfifo_rempty), .CFIFO_REN(cfifo_ren), .CFIFO_RDATA(cfifo_rdata),
        .WFIFO_REMPTY(wfifo_rempty), .WFIFO_REN(wfifo_ren), .WFIFO_RDATA(wfifo_rdata),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WRITE(req_write),
        .REQ_ROW(req_row), .REQ_BANK(req_bank), .REQ_COL(req_col),
        .REQ_WDATA(req_wdata), .REQ_BE(req_be), .ERR(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          drop;
        bit          wr;
        logic [31:0] row;
        logic [31:0] bank;
        logic [31:0] col;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    exp_t        exp_q[$];
    logic [35:0] cq[$];
    logic [31:0] wq[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit c_pop  = 1'b0;
    bit w_pop  = 1'b0;
    bit w_hold = 1'b0;
    bit b2b    = 1'b0;
    int last_acc = -1;
    int ready_mode = 1;   // 0 low, 1 high, 2 random

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit model_drop(input int size, input logic [31:0] addr);
`ifdef SDRAM_CMD_ALIGN_CHECK_EN
        return (size > 2) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: expected request computed arithmetically from the command.
    task automatic push_cmd(input bit wr, input int size, input logic [31:0] addr, input logic [31:0] data);
        exp_t        e;
        int          lsb;
        logic [31:0] sz32;
        lsb    = int'(addr % 4);
        sz32   = size;
        e.drop = model_drop(size, addr);
        e.wr   = wr;
        e.col  = (addr / 4) % (2 ** COL_BITS);
        e.bank = (addr / (2 ** (2 + COL_BITS))) % (2 ** BA_BITS);
        e.row  = (addr / (2 ** (2 + COL_BITS + BA_BITS))) % (2 ** ROW_BITS);
        if (size == 0)      e.be = 4'(1 << lsb);
        else if (size == 1) e.be = (lsb >= 2) ? 4'd12 : 4'd3;
        else                e.be = 4'd15;
        e.wdata = wr ? data : 32'h0;
        cq.push_back({wr, sz32[2:0], addr});
        if (wr) wq.push_back(data);
        exp_q.push_back(e);
    endtask

    // FIFO and REQ_READY driver: pops take effect just after the edge that ends the REN cycle.
    initial begin
        cfifo_rempty = 1'b1; wfifo_rempty = 1'b1;
        cfifo_rdata = 36'h0; wfifo_rdata = 32'h0; req_ready = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (c_pop && cq.size() > 0) cfifo_rdata = cq.pop_front();
            if (w_pop && wq.size() > 0) wfifo_rdata = wq.pop_front();
            cfifo_rempty = (cq.size() == 0);
            wfifo_rempty = (wq.size() == 0) || w_hold;
            case (ready_mode)
                0:       req_ready = 1'b0;
                1:       req_ready = 1'b1;
                default: req_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            c_pop = cfifo_ren;
            w_pop = wfifo_ren;
        end
    end

    // Monitor: protocol checks every cycle, scoreboard pop on accept or ERR.
    initial begin
        exp_t        e;
        bit          prev_valid = 1'b0, prev_ready = 1'b0, prev_acc = 1'b0;
        logic [61:0] prev_fields = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0; prev_ready = 1'b0; prev_acc = 1'b0;
            end else begin
                chk("cfifo_pop_while_empty", 64'(cfifo_ren & cfifo_rempty), 64'd0);
                chk("wfifo_pop_while_empty", 64'(wfifo_ren & wfifo_rempty), 64'd0);
                chk("pop_during_out", 64'(cfifo_ren & req_valid), 64'd0);
                if (prev_acc && !cfifo_rempty) chk("pop_after_accept", 64'(cfifo_ren), 64'd1);
                if (prev_valid && !prev_ready) begin
                    chk("hold_valid", 64'(req_valid), 64'd1);
                    chk("hold_fields", 64'({req_write, req_row, req_bank, req_col, req_be, req_wdata}),
                        64'(prev_fields));
                end
                if (req_valid) chk("valid_has_expectation", 64'(exp_q.size() > 0), 64'd1);
                if (err) begin
                    if (exp_q.size() == 0) chk("err_expected", 64'd0, 64'd1);
                    else begin
                        e = exp_q.pop_front();
                        chk("err_expected", 64'(e.drop), 64'd1);
                    end
                end
                if (req_valid && req_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("issued_not_dropped", 64'(e.drop), 64'd0);
                    chk("req_write", 64'(req_write), 64'(e.wr));
                    chk("req_row",   64'(req_row),   64'(e.row));
                    chk("req_bank",  64'(req_bank),  64'(e.bank));
                    chk("req_col",   64'(req_col),   64'(e.col));
                    chk("req_be",    64'(req_be),    64'(e.be));
                    chk("req_wdata", 64'(req_wdata), 64'(e.wdata));
                    if (b2b && last_acc >= 0) chk("b2b_spacing", 64'(cyc - last_acc), 64'd3);
                    last_acc = cyc;
                end
                prev_valid  = req_valid;
                prev_ready  = req_ready;
                prev_acc    = req_valid && req_ready;
                prev_fields = {req_write, req_row, req_bank, req_col, req_be, req_wdata};
            end
        end
    end

    task automatic drain();
        int t = 0;
        while ((exp_q.size() > 0 || cq.size() > 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk("drain_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_wfifo_empty", 64'(wq.size()), 64'd0);
    endtask

    task automatic latency(input string name, input int req);
        int cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!req_valid && cnt < 20);
        chk(name, 64'(cnt), 64'(req));
    endtask

    initial begin
        int vcnt;
        // Reset state, with both FIFOs claiming data so the pop gating is exercised.
        #2;
        cfifo_rempty = 1'b0; wfifo_rempty = 1'b0;
        #1;
        chk("rst_ctrl", 64'({cfifo_ren, wfifo_ren, req_valid, err, req_write}), 64'd0);
        chk("rst_data", 64'({req_row, req_bank, req_col, req_be, req_wdata}), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Directed read and its issue latency.
        @(negedge clk);
        push_cmd(1'b0, 2, 32'h0012_3458, 32'h0);
        latency("read_latency", 3);
        drain();

        // Write with data already available.
        push_cmd(1'b1, 1, 32'h0000_1002, $urandom);
        latency("write_latency", 4);
        drain();

        // Write waiting five cycles for data.
        w_hold = 1'b1;
        push_cmd(1'b1, 0, 32'h0000_0AB3, 32'hDEAD_BEEF);
        repeat (3) @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("wwait_no_valid", 64'(req_valid), 64'd0);
        end
        w_hold = 1'b0;
        drain();

        // Core stalls for ten cycles with a second command waiting.
        ready_mode = 0;
        push_cmd(1'b0, 0, $urandom, 32'h0);
        push_cmd(1'b0, 1, $urandom, 32'h0);
        vcnt = 0;
        while (!req_valid && vcnt < 20) begin @(negedge clk); vcnt++; end
        chk("stall_valid_seen", 64'(req_valid), 64'd1);
        repeat (10) begin
            @(negedge clk);
            chk("stall_no_pop", 64'(cfifo_ren), 64'd0);
        end
        ready_mode = 1;
        drain();

        // Misaligned word write followed by a normal write (data pairing).
        push_cmd(1'b1, 2, 32'h0000_0002, 32'h1234_5678);
        push_cmd(1'b1, 2, 32'h0000_0100, 32'hCAFE_F00D);
        drain();

        // Reset while waiting for write data.
        w_hold = 1'b1;
        push_cmd(1'b1, 0, 32'h00FF_1234, 32'hA5A5_5A5A);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ctrl", 64'({cfifo_ren, wfifo_ren, req_valid, err, req_write}), 64'd0);
        chk("midrst_data", 64'({req_row, req_bank, req_col, req_be, req_wdata}), 64'd0);
        exp_q.delete(); cq.delete(); wq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0; w_hold = 1'b0;
        vcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (req_valid) vcnt++;
        end
        chk("post_reset_no_valid", 64'(vcnt), 64'd0);

        // Back-to-back reads with the core always ready.
        b2b = 1'b1; last_acc = -1;
        for (int i = 0; i < 6; i++) push_cmd(1'b0, 2, $urandom & 32'hFFFF_FFFC, 32'h0);
        drain();
        b2b = 1'b0;

        // Randomised traffic.
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0)
                push_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom, $urandom);
            w_hold = ($urandom_range(0, 3) == 0);
        end
        w_hold = 1'b0;
        ready_mode = 1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
